// File: rtl/period_meter_if.sv
// ============================================================================
// period_meter_if : counter/signal inputs and period result handshake bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface period_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] counter_in;
    logic             sig_in;
    logic             enable;
    logic [WIDTH-1:0] period_out;
    logic             period_valid;
    logic             period_ready;
    logic             overrun;
    logic             timeout;

    modport master (
        input  counter_in, sig_in, enable, period_ready,
        output period_out, period_valid, overrun, timeout
    );

    modport slave (
        output counter_in, sig_in, enable, period_ready,
        input  period_out, period_valid, overrun, timeout
    );
endinterface

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// period_meter : timestamps rising edges of an async input against a
//                free-running counter and reports the delta between edges
// Revision 1.0
// ============================================================================
`default_nettype none

module period_meter #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] MAX_PERIOD = {WIDTH{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    period_meter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] stamp_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             overrun_q;
    logic             timeout_q;

    logic             rise;
    logic [WIDTH-1:0] elapsed;
    logic             over_limit;
    logic             new_result;
    logic             expired;

    assign rise    = s2_q & ~s3_q;
    assign elapsed = bus.counter_in - stamp_q;

    // An all-ones limit can never be exceeded, so skip the comparator entirely
    generate
        if (MAX_PERIOD == {WIDTH{1'b1}}) begin : g_no_timeout
            assign over_limit = 1'b0;
        end else begin : g_timeout
            assign over_limit = (elapsed > MAX_PERIOD);
        end
    endgenerate

    assign new_result = bus.enable && (state_q == S_MEAS) && rise;
    assign expired    = bus.enable && (state_q == S_MEAS) && !rise && over_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stamp_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // The output register keeps handshaking while disabled so a pending result can drain
            if (new_result) begin
                if (!valid_q || bus.period_ready) begin
                    period_q <= elapsed;
                    valid_q  <= 1'b1;
                end
            end else if (valid_q && bus.period_ready) begin
                valid_q <= 1'b0;
            end

            if (!bus.enable) begin
                state_q   <= S_IDLE;
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (new_result && valid_q && !bus.period_ready) begin
                    overrun_q <= 1'b1;
                end
                if (expired) begin
                    timeout_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: state_q <= S_ARM;
                    S_ARM: begin
                        if (rise) begin
                            stamp_q <= bus.counter_in;
                            state_q <= S_MEAS;
                        end
                    end
                    S_MEAS: begin
                        if (rise) begin
                            stamp_q <= bus.counter_in;
                        end else if (expired) begin
                            state_q <= S_ARM;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.period_out   = period_q;
    assign bus.period_valid = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// tb_period_meter : scoreboard bench for period_meter (MAX_PERIOD = 1000)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_period_meter;

    logic clk;
    logic reset;

    period_meter_if #(.WIDTH(32)) bus ();

    period_meter #(
        .WIDTH      (32),
        .MAX_PERIOD (32'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] model_stamp = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running counter, updated 1 ns after each active edge
    initial begin
        bus.counter_in = 32'd0;
        forever begin
            @(posedge clk);
            #1 bus.counter_in = bus.counter_in + 32'd1;
        end
    end

    // Capture every completed transfer into the observed queue
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.period_valid === 1'b1 && bus.period_ready === 1'b1)
                got_q.push_back(bus.period_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Raise sig_in for hi cycles then low for lo cycles; delta is the period the DUT should see
    task automatic edge_pulse(input int hi, input int lo, input bit push, output logic [31:0] delta);
        logic [31:0] ns;
        ns          = bus.counter_in + 32'd2;
        delta       = ns - model_stamp;
        model_stamp = ns;
        if (push) exp_q.push_back(delta);
        bus.sig_in = 1'b1;
        tick(hi);
        bus.sig_in = 1'b0;
        tick(lo);
    endtask

    task automatic restart(input logic rdy);
        bus.enable       = 1'b0;
        bus.period_ready = 1'b1;
        tick(3);
        got_q.delete();
        exp_q.delete();
        bus.period_ready = rdy;
        bus.enable       = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sig_in = 1'b0; bus.enable = 1'b0; bus.period_ready = 1'b0;
        tick(3);
        checks++; if (bus.period_out !== 32'd0) begin errors++; $display("FAIL reset_period_out got=%h exp=0", bus.period_out); end
        checks++; if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.period_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        logic [31:0] d, g, e;
        restart(1'b1);
        edge_pulse(50, 50, 1'b0, d);
        for (int i = 0; i < 4; i++) begin
            edge_pulse(50, 50, 1'b0, d);
            exp_q.push_back(32'd100);
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL basic_period got=%0d exp=%0d", g, e); end
        end
        checks++; if (bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL basic_flags got=%b%b exp=00", bus.overrun, bus.timeout); end
    endtask

    task automatic test_wrap();
        logic [31:0] d, g;
        restart(1'b1);
        bus.counter_in = 32'hFFFF_FFEE;
        edge_pulse(16, 16, 1'b0, d);
        edge_pulse(16, 16, 1'b0, d);
        exp_q.push_back(32'h0000_0020);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++; if (g !== exp_q.pop_front()) begin errors++; $display("FAIL wrap_period got=%h exp=00000020", g); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, a, b, c, g, e;
        restart(1'b0);
        edge_pulse(25, 25, 1'b0, d);
        edge_pulse(25, 25, 1'b1, a);
        edge_pulse(25, 25, 1'b0, d);
        checks++; if (bus.period_valid !== 1'b1 || bus.period_out !== 32'd50) begin errors++; $display("FAIL bp_held got=%b/%0d exp=1/50", bus.period_valid, bus.period_out); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", bus.overrun); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_transfer got=%0d exp=0", got_q.size()); end
        bus.period_ready = 1'b1; tick(1); bus.period_ready = 1'b0;
        checks++; if (bus.period_valid !== 1'b0 || bus.period_out !== 32'd50) begin errors++; $display("FAIL bp_drain got=%b/%0d exp=0/50", bus.period_valid, bus.period_out); end
        edge_pulse(25, 25, 1'b1, b);
        c = bus.counter_in + 32'd2 - model_stamp;
        model_stamp = bus.counter_in + 32'd2;
        exp_q.push_back(c);
        bus.sig_in = 1'b1;
        tick(2);
        bus.period_ready = 1'b1; tick(1); bus.period_ready = 1'b0;
        checks++; if (bus.period_valid !== 1'b1 || bus.period_out !== c) begin errors++; $display("FAIL bp_coincide got=%b/%0d exp=1/%0d", bus.period_valid, bus.period_out, c); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky got=%b exp=1", bus.overrun); end
        bus.sig_in = 1'b0; tick(25);
        bus.period_ready = 1'b1; tick(1); bus.period_ready = 1'b0; tick(1);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL bp_period got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, g, elapsed;
        bit          seen;
        restart(1'b1);
        edge_pulse(5, 5, 1'b0, d);
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (bus.timeout === 1'b1) begin seen = 1'b1; break; end
            tick(1);
        end
        elapsed = bus.counter_in - 32'd1 - model_stamp;
        checks++; if (!seen) begin errors++; $display("FAIL to_seen got=0 exp=1 within 1500 cycles"); end
        checks++; if (seen && elapsed !== 32'd1001) begin errors++; $display("FAIL to_elapsed got=%0d exp=1001", elapsed); end
        edge_pulse(5, 5, 1'b0, d);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL to_rearm got=%0d results exp=0", got_q.size()); end
        edge_pulse(5, 5, 1'b0, d);
        exp_q.push_back(32'd10);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL to_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++; if (g !== exp_q.pop_front()) begin errors++; $display("FAIL to_period got=%0d exp=10", g); end
        end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", bus.timeout); end
    endtask

    task automatic test_enable_reset();
        logic [31:0] d, g, e;
        restart(1'b0);
        edge_pulse(20, 20, 1'b0, d);
        edge_pulse(20, 20, 1'b1, d);
        edge_pulse(20, 20, 1'b0, d);
        bus.enable = 1'b0; tick(1);
        checks++; if (bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL en_clear got=%b%b exp=00", bus.overrun, bus.timeout); end
        checks++; if (bus.period_valid !== 1'b1 || bus.period_out !== 32'd40) begin errors++; $display("FAIL en_pending got=%b/%0d exp=1/40", bus.period_valid, bus.period_out); end
        bus.enable = 1'b1; tick(2);
        edge_pulse(20, 20, 1'b0, d);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL en_rearm got=%b exp=0", bus.overrun); end
        bus.period_ready = 1'b1; tick(1); bus.period_ready = 1'b0;
        checks++; if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL en_consumed got=%b exp=0", bus.period_valid); end
        edge_pulse(20, 20, 1'b0, d);
        edge_pulse(20, 20, 1'b0, d);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.period_out !== 32'd0 || bus.period_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.timeout !== 1'b0)
            begin errors++; $display("FAIL rst_async got=%h/%b/%b/%b exp=0/0/0/0", bus.period_out, bus.period_valid, bus.overrun, bus.timeout); end
        reset = 1'b0;
        tick(2);
        edge_pulse(20, 20, 1'b0, d);
        checks++; if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL rst_rearm got=%b exp=0", bus.period_valid); end
        bus.period_ready = 1'b1;
        edge_pulse(20, 20, 1'b1, d);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL en_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL en_period got=%0d exp=%0d", g, e); end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d, p, g;
        restart(1'b1);
        edge_pulse(10, 10, 1'b0, d);
        p = bus.counter_in + 32'd2 - model_stamp;
        model_stamp = bus.counter_in + 32'd2;
        exp_q.push_back(p);
        bus.sig_in = 1'b1;
        tick(1);
        bus.sig_in = 1'b0;
        checks++; if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL gl_edge1 got=%b exp=0", bus.period_valid); end
        tick(1);
        checks++; if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL gl_edge2 got=%b exp=0", bus.period_valid); end
        tick(1);
        checks++; if (bus.period_valid !== 1'b1) begin errors++; $display("FAIL gl_edge3 got=%b exp=1", bus.period_valid); end
        tick(20);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL gl_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++; if (g !== exp_q.pop_front()) begin errors++; $display("FAIL gl_period got=%0d exp=%0d", g, p); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_enable_reset();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
- Reader for the free-running cycle counter. It timestamps rising edges of an asynchronous input against the counter bus and reports the counter delta between successive edges as a period measurement.
- Results leave through a valid/ready output register to a downstream consumer (display or UART formatter).
- Sits beside the counter and shares its clock domain.

Parameters:
- WIDTH, 32, width of the counter bus and of the period result.
- MAX_PERIOD, 32'hFFFF_FFFF, largest legal elapsed count. Any elapsed count above this is a timeout.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- counter_in  input  WIDTH  free-running counter value, synchronous to clk.
- sig_in  input  1  asynchronous signal under measurement.
- enable  input  1  measurement enable, synchronous.
- period_out  output  WIDTH  measured period, in counter ticks.
- period_valid  output  1  period_out holds an unconsumed result.
- period_ready  input  1  consumer accepts the result in this cycle.
- overrun  output  1  sticky: a result was dropped because the output register was full.
- timeout  output  1  sticky: elapsed count exceeded MAX_PERIOD.

Behaviour:
- Reset values: period_out=0, period_valid=0, overrun=0, timeout=0, state=IDLE, synchronizer flops=0, stamp=0.
- Input synchronization:
  - sig_in passes through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
  - rise = s2 & ~s3.
  - A sig_in high first sampled at edge k produces rise during the cycle after edge k+1.
  - counter_in is sampled at the clock edge that ends the rise cycle.
- State machine:
  - IDLE: outputs hold. When enable=1, go to ARM.
  - ARM: on rise, stamp<=counter_in and go to MEAS. No result is produced.
  - MEAS, on rise: result = (counter_in - stamp) mod 2^WIDTH, then stamp<=counter_in. Stay in MEAS.
  - MEAS, timeout: when there is no rise and the elapsed count (counter_in - stamp) mod 2^WIDTH > MAX_PERIOD, set timeout=1 and go to ARM.
  - MEAS, rise wins: if rise and timeout coincide, rise takes priority and the result is produced.
  - Any state: enable=0 gives IDLE on the next edge and clears overrun and timeout. period_out/period_valid are untouched, so a pending result stays readable.
- Arithmetic:
  - Unsigned modulo-2^WIDTH subtraction, so a single counter wrap gives the correct period.
  - A stalled counter gives result 0, which is reported as a normal result.
  - Multiple wraps are not detectable; MAX_PERIOD guards against them.
- Output handshake:
  - Transfer occurs when period_valid & period_ready at a clock edge.
  - New result with period_valid=0: load period_out, period_valid=1 at the same edge.
  - New result with period_valid=1 & period_ready=1: load the new value, period_valid stays 1, no overrun.
  - New result with period_valid=1 & period_ready=0: drop the new result, period_out unchanged, overrun=1. stamp still updates.
  - No new result & transfer: period_valid=0 and period_out holds its last value.
- Flags: overrun and timeout are sticky until reset or enable=0.
- Latency: edge to result is 3 clk edges from first sampling of sig_in high to period_valid=1 (2 synchronizer edges plus the load edge).
- Reset asserted mid-measurement: everything clears asynchronously. After release the block starts in IDLE and needs a fresh arm edge before it produces any result.

Test Plan:
1. Basic measurement:
   - Stimulus: enable=1, period_ready=1, sig_in toggling with a rising edge every 100 clk, counter incrementing each clk.
   - Response: first rise only arms; every later rise gives period_out=100, period_valid one cycle per result, overrun=0, timeout=0.
2. Wrap-around:
   - Stimulus: counter preset so the stamp is 32'hFFFF_FFF0 and the next rise sees 32'h0000_0010.
   - Response: period_out=32'h20.
3. Backpressure:
   - Stimulus: period_ready=0, rising edges every 50 clk.
   - Response: first result 50 held, second result dropped and overrun=1.
   - Then period_ready=1 for one cycle with no new result: period_valid=0.
   - Then period_ready=1 in the same cycle as a new result: the new value loads, period_valid stays 1, overrun unchanged.
4. Timeout:
   - Stimulus: MAX_PERIOD=1000, single arm edge, then no edge for 1500 clk.
   - Response: timeout=1 when elapsed=1001, state returns to ARM.
   - The next edge re-arms only; the edge after it reports the correct period.
5. Enable and reset:
   - Stimulus: enable dropped mid-measurement while a result is pending.
   - Response: overrun/timeout cleared, result still valid until consumed, re-enable needs an arm edge.
   - Stimulus: reset pulsed asynchronously between clk edges.
   - Response: all outputs 0 immediately.
6. Glitch/edge timing:
   - Stimulus: sig_in pulse 1 clk wide.
   - Response: exactly one rise is detected, and period_valid asserts 3 edges after the first sample.
